// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: FSM state encoding
// and default datapath sizing.
package div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,q} left,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic        [WIDTH:0] shifted;
  logic signed [WIDTH:0] trial;

  // One extra bit holds the borrow, so a negative trial is simply trial[WIDTH].
  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = $signed(shifted - {1'b0, divisor_i});

  assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: one restoring step per clock on magnitudes,
// sign fix-up at the end; quotient on lo, remainder on hi, divide-by-zero flag.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Two's-complement negate modulo 2^WIDTH; |most-negative| stays itself.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_i       (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            div0_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d      = cneg(a, a[WIDTH-1]);
            dvs_d      = cneg(b, b[WIDTH-1]);
            rem_d      = '0;
            cnt_d      = '0;
            sign_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            sign_rem_d = a[WIDTH-1];
            div0_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
      end
      SIGN: begin
        lo_d    = cneg(quo_q, sign_quo_q);
        hi_d    = cneg(rem_q, sign_rem_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divisions with hand-computed
// results and latencies, plus sequences for ignored starts and async reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div0;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done; returns at the done cycle.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] prev_lo, input logic [31:0] prev_hi,
                        output int lat, output int busy_cnt, output int unstable);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0; unstable = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lo !== prev_lo || hi !== prev_hi) unstable++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat, bcnt, unst, nd;
    logic [31:0] plo, phi;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    vecs[3]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34};
    vecs[4]  = '{32'd5,        32'd0,        32'd3,        32'd1,        1'b1, 1};
    vecs[5]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
    vecs[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34};
    vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};
    vecs[9]  = '{32'd100,      32'd10,       32'd10,       32'd0,        1'b0, 34};
    vecs[10] = '{32'hFFFFFFF7, 32'hFFFFFFFC, 32'd2,        32'hFFFFFFFF, 1'b0, 34};
    vecs[11] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 34};
    vecs[12] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 34};
    vecs[13] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34};
    vecs[14] = '{32'd0,        32'd0,        32'd1,        32'd0,        1'b1, 1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    plo = '0; phi = '0;
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, plo, phi, lat, bcnt, unst);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].div0});
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      if (vecs[i].lat == 34) begin
        chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd33);
        chk($sformatf("v%0d_hilo_stable", i), 32'(unst), 32'd0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      plo = vecs[i].lo; phi = vecs[i].hi;
    end

    // Second start during CALC, then another while in DONE: both ignored.
    @(negedge clk);
    a = 32'd7; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin a = 32'd100; b = 32'd10; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", 32'(lat), 32'd34);
    chk("ign_lo", lo, 32'd3);
    chk("ign_hi", hi, 32'd1);
    a = 32'd100; b = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_state_busy", {31'd0, busy}, 32'd0);
    count_dones(40, nd);
    chk("ign_extra_dones", 32'(nd), 32'd0);
    chk("ign_lo_kept", lo, 32'd3);

    // Reset during the done cycle of a divide-by-zero clears done/div0 at once.
    run_op(32'd5, 32'd0, 32'd3, 32'd1, lat, bcnt, unst);
    chk("z_latency", 32'(lat), 32'd1);
    chk("z_div0", {31'd0, div0}, 32'd1);
    reset = 1'b0;
    #1;
    chk("z_rst_done", {31'd0, done}, 32'd0);
    chk("z_rst_div0", {31'd0, div0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Restore hi/lo, then reset in the middle of an operation.
    run_op(32'd7, 32'd2, 32'd0, 32'd0, lat, bcnt, unst);
    chk("pre_lo", lo, 32'd3);
    @(negedge clk);
    a = 32'd7; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_div0", {31'd0, div0}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_dones(50, nd);
    chk("mid_no_done", 32'(nd), 32'd0);
    chk("mid_idle_busy", {31'd0, busy}, 32'd0);

    run_op(32'd9, 32'd4, 32'd0, 32'd0, lat, bcnt, unst);
    chk("post_latency", 32'(lat), 32'd34);
    chk("post_lo", lo, 32'd2);
    chk("post_hi", hi, 32'd1);
    chk("post_div0", {31'd0, div0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
